// File: rtl/dot_product.sv
// dot_product: memory-backed pipelined dot-product engine with file loader and result write-back
module dot_product #(
  parameter int Addr_Width = 4,
  parameter int Ram_Depth = 1 << Addr_Width,
  parameter int Nums_SRAM_In = 2,
  parameter int Nums_SRAM_Out = 1,
  parameter int Nums_SRAM = Nums_SRAM_In + Nums_SRAM_Out,
  parameter int Nums_Data_in_bits = 4,
  parameter int Nums_Data = 1 << Nums_Data_in_bits,
  parameter int Nums_Pipeline_Stages = 4,
  parameter int Pipeline_Tail = Nums_Pipeline_Stages - 1,
  parameter int Total_Computation_Steps = Nums_Data + Pipeline_Tail,
  parameter int Para_Deg = 1,
  parameter int Data_Width_In = 8,
  parameter int Data_Width_Out = 16
) (
  input  logic clk,
  input  logic Mem_reset,
  input  logic Comp_reset,
  input  logic Mem_Index_reset,
  input  logic PE_reset,
  input  logic Computing,
  input  logic load_old_output,
  input  logic load_from_file,
  input  logic [Nums_SRAM_In*Para_Deg*Data_Width_In-1:0] input_data_from_file,
  input  logic [Nums_SRAM_Out*Para_Deg*Data_Width_Out-1:0] output_data_from_file,
  output logic [Para_Deg*Data_Width_Out-1:0] result,
  output logic [Nums_Data_in_bits:0] state,
  output logic [Nums_SRAM*Addr_Width-1:0] test_r,
  output logic [Nums_SRAM*Addr_Width-1:0] test_w,
  output logic [Para_Deg*Data_Width_In-1:0] test_data
);
  localparam int SW = Nums_Data_in_bits + 1;
  localparam int IW = Para_Deg * Data_Width_In;
  localparam logic [SW-1:0] done_st = SW'(Total_Computation_Steps);
  localparam logic [SW-1:0] last_st = SW'(Nums_Data);
  logic [Para_Deg-1:0][Data_Width_In-1:0] mem_in [Nums_SRAM_In][Ram_Depth];
  logic [Para_Deg-1:0][Data_Width_Out-1:0] mem_out [Ram_Depth];
  logic [Para_Deg-1:0][Data_Width_In-1:0] rd_a, rd_b;
  logic [Para_Deg-1:0][Data_Width_Out-1:0] prod, acc;
  logic [Addr_Width-1:0] waddr, raddr;
  logic done_q, v1, v2, v3, run, issue, wb;
  assign run = Computing && !load_from_file && state < done_st;
  assign issue = run && state < last_st;
  assign wb = state == done_st && !done_q;
  assign result = acc;
  assign test_r = {Nums_SRAM{raddr}};
  assign test_w = {Nums_SRAM{waddr}};
  assign test_data = rd_a;
  always_ff @(posedge clk or posedge Mem_reset)
    if (Mem_reset) begin
      for (int s = 0; s < Nums_SRAM_In; s++)
        for (int a = 0; a < Ram_Depth; a++)
          mem_in[s][a] <= '0;
      for (int a = 0; a < Ram_Depth; a++)
        mem_out[a] <= '0;
    end else if (load_from_file) begin
      for (int s = 0; s < Nums_SRAM_In; s++)
        mem_in[s][waddr] <= input_data_from_file[s*IW +: IW];
      mem_out[waddr] <= output_data_from_file[Para_Deg*Data_Width_Out-1:0];
    end else if (wb) begin
      mem_out[0] <= acc;
    end
  always_ff @(posedge clk or posedge Mem_reset or posedge Mem_Index_reset)
    if (Mem_reset || Mem_Index_reset)
      waddr <= '0;
    else if (load_from_file)
      waddr <= waddr + 1'b1;
  always_ff @(posedge clk or posedge Mem_reset or posedge Comp_reset or posedge Mem_Index_reset)
    if (Mem_reset || Comp_reset || Mem_Index_reset)
      raddr <= '0;
    else if (issue)
      raddr <= Addr_Width'(state);
  // done_q marks that the finished accumulator has already been written back
  always_ff @(posedge clk or posedge Comp_reset)
    if (Comp_reset) begin
      state <= '0;
      done_q <= 1'b0;
    end else begin
      state <= run ? state + 1'b1 : state;
      done_q <= state == done_st;
    end
  always_ff @(posedge clk or posedge PE_reset)
    if (PE_reset) begin
      {v1, v2, v3} <= '0;
      rd_a <= '0;
      rd_b <= '0;
      prod <= '0;
      acc <= '0;
    end else begin
      v1 <= issue;
      v2 <= v1;
      v3 <= v2;
      rd_a <= mem_in[0][raddr];
      rd_b <= mem_in[1][raddr];
      for (int k = 0; k < Para_Deg; k++) begin
        prod[k] <= Data_Width_Out'(rd_a[k]) * Data_Width_Out'(rd_b[k]);
        acc[k] <= (load_old_output && !Computing) ? mem_out[0][k] : v3 ? acc[k] + prod[k] : acc[k];
      end
    end
endmodule

// File: tb/tb_dot_product.sv
// tb_dot_product: randomized self-checking bench for dot_product against an arithmetic reference
module tb_dot_product;
  logic clk = 0;
  logic Mem_reset = 0, Comp_reset = 0, Mem_Index_reset = 0, PE_reset = 0;
  logic Computing = 0, load_old_output = 0, load_from_file = 0;
  logic [15:0] input_data_from_file = '0;
  logic [15:0] output_data_from_file = '0;
  logic [15:0] result;
  logic [4:0] state;
  logic [11:0] test_r, test_w;
  logic [7:0] test_data;
  int n_vec = 0, n_err = 0;
  int a_v[16], b_v[16];

  dot_product dut (
    .clk(clk), .Mem_reset(Mem_reset), .Comp_reset(Comp_reset),
    .Mem_Index_reset(Mem_Index_reset), .PE_reset(PE_reset), .Computing(Computing),
    .load_old_output(load_old_output), .load_from_file(load_from_file),
    .input_data_from_file(input_data_from_file), .output_data_from_file(output_data_from_file),
    .result(result), .state(state), .test_r(test_r), .test_w(test_w), .test_data(test_data)
  );

  always #5 clk = ~clk;

  function automatic int expect_sum(input int pre);
    int s = pre;
    for (int i = 0; i < 16; i++) s += a_v[i] * b_v[i];
    return s % 65536;
  endfunction

  function automatic logic [11:0] addr3(input int a);
    logic [3:0] x = 4'(a);
    return {x, x, x};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vecs(input int out0);
    Mem_Index_reset = 1; #1; Mem_Index_reset = 0;
    for (int i = 0; i < 16; i++) begin
      input_data_from_file = {8'(b_v[i]), 8'(a_v[i])};
      output_data_from_file = (i == 0) ? 16'(out0) : 16'h0;
      load_from_file = 1;
      n_vec++;
      if (test_w !== addr3(i)) begin
        n_err++;
        $display("FAIL load_waddr[%0d]: got %h want %h", i, test_w, addr3(i));
      end
      step();
    end
    load_from_file = 0;
  endtask

  task automatic clear_comp();
    Comp_reset = 1; PE_reset = 1; #1; Comp_reset = 0; PE_reset = 0;
  endtask

  task automatic do_run(input bit pre);
    clear_comp();
    if (pre) begin
      load_old_output = 1; step(); load_old_output = 0;
    end
    Computing = 1;
    repeat (19) step();
    Computing = 0;
    step();
  endtask

  task automatic test_reset();
    #2; Mem_reset = 1; Comp_reset = 1; Mem_Index_reset = 1; PE_reset = 1; #2;
    n_vec++;
    if ({result, state, test_r, test_w, test_data} !== '0) begin
      n_err++;
      $display("FAIL reset: got r=%0d s=%0d tr=%h tw=%h td=%h want all 0", result, state, test_r, test_w, test_data);
    end
    Mem_reset = 0; Comp_reset = 0; Mem_Index_reset = 0; PE_reset = 0;
    step();
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 16; i++) begin a_v[i] = i + 1; b_v[i] = 1; end
    load_vecs(0);
    do_run(0);
    n_vec++;
    if (result !== 16'd136) begin n_err++; $display("FAIL ramp_result: got %0d want 136", result); end
    n_vec++;
    if (state !== 5'd19) begin n_err++; $display("FAIL ramp_state: got %0d want 19", state); end
    n_vec++;
    if (test_r !== addr3(15)) begin n_err++; $display("FAIL ramp_raddr: got %h want %h", test_r, addr3(15)); end
    n_vec++;
    if (test_data !== 8'd16) begin n_err++; $display("FAIL ramp_tdata: got %0d want 16", test_data); end
    Computing = 1; repeat (3) step(); Computing = 0;
    n_vec++;
    if (state !== 5'd19 || result !== 16'd136) begin
      n_err++; $display("FAIL done_hold: got s=%0d r=%0d want 19/136", state, result);
    end
  endtask

  task automatic test_square_writeback();
    for (int i = 0; i < 16; i++) begin a_v[i] = i; b_v[i] = i; end
    load_vecs(7);
    do_run(0);
    n_vec++;
    if (result !== 16'd1240) begin n_err++; $display("FAIL square_result: got %0d want 1240", result); end
    clear_comp();
    load_old_output = 1; step(); load_old_output = 0;
    n_vec++;
    if (result !== 16'd1240) begin n_err++; $display("FAIL writeback_readback: got %0d want 1240", result); end
  endtask

  task automatic test_wrap_max();
    for (int i = 0; i < 16; i++) begin a_v[i] = 255; b_v[i] = 255; end
    load_vecs(0);
    do_run(0);
    n_vec++;
    if (result !== 16'd57360) begin n_err++; $display("FAIL max_wrap: got %0d want 57360", result); end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 16; i++) begin a_v[i] = 1; b_v[i] = 1; end
    load_vecs(100);
    do_run(1);
    n_vec++;
    if (result !== 16'd116) begin n_err++; $display("FAIL preload: got %0d want 116", result); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int pre = $urandom_range(0, 65535);
      bit use_pre = 1'($urandom_range(0, 1));
      int exp_r;
      for (int i = 0; i < 16; i++) begin a_v[i] = $urandom_range(0, 255); b_v[i] = $urandom_range(0, 255); end
      load_vecs(pre);
      do_run(use_pre);
      exp_r = expect_sum(use_pre ? pre : 0);
      n_vec++;
      if (result !== 16'(exp_r)) begin
        n_err++; $display("FAIL random[%0d]: got %0d want %0d", t, result, exp_r);
      end
    end
  endtask

  task automatic test_pause();
    int exp_r;
    for (int i = 0; i < 16; i++) begin a_v[i] = $urandom_range(0, 255); b_v[i] = $urandom_range(0, 255); end
    load_vecs(0);
    exp_r = expect_sum(0);
    clear_comp();
    Computing = 1; repeat (5) step(); Computing = 0;
    repeat (3) step();
    n_vec++;
    if (state !== 5'd5) begin n_err++; $display("FAIL pause_hold: got %0d want 5", state); end
    Computing = 1; repeat (14) step(); Computing = 0;
    step();
    n_vec++;
    if (state !== 5'd19 || result !== 16'(exp_r)) begin
      n_err++; $display("FAIL pause_resume: got s=%0d r=%0d want 19/%0d", state, result, exp_r);
    end
  endtask

  task automatic test_comp_reset_mid();
    for (int i = 0; i < 16; i++) begin a_v[i] = i + 1; b_v[i] = 1; end
    load_vecs(0);
    clear_comp();
    Computing = 1; repeat (8) step();
    n_vec++;
    if (state !== 5'd8) begin n_err++; $display("FAIL mid_state: got %0d want 8", state); end
    Comp_reset = 1; #1;
    n_vec++;
    if (state !== 5'd0 || test_r !== 12'h0) begin
      n_err++; $display("FAIL async_comp_reset: got s=%0d tr=%h want 0/000", state, test_r);
    end
    Computing = 0; Comp_reset = 0;
    step();
    do_run(0);
    n_vec++;
    if (result !== 16'd136) begin n_err++; $display("FAIL rerun: got %0d want 136", result); end
  endtask

  task automatic test_load_wrap();
    for (int i = 0; i < 16; i++) begin a_v[i] = 3; b_v[i] = 2; end
    clear_comp();
    Computing = 1;
    load_vecs(0);
    n_vec++;
    if (test_w !== 12'h0) begin n_err++; $display("FAIL wrap_before17: got %h want 000", test_w); end
    input_data_from_file = {8'(b_v[0]), 8'(a_v[0])};
    load_from_file = 1; step(); load_from_file = 0;
    n_vec++;
    if (test_w !== addr3(1)) begin n_err++; $display("FAIL wrap_after17: got %h want %h", test_w, addr3(1)); end
    n_vec++;
    if (state !== 5'd0) begin n_err++; $display("FAIL load_over_compute: got %0d want 0", state); end
    Computing = 0;
    do_run(0);
    n_vec++;
    if (result !== 16'd96) begin n_err++; $display("FAIL wrap_run: got %0d want 96", result); end
  endtask

  task automatic test_mem_reset();
    for (int i = 0; i < 16; i++) begin a_v[i] = 9; b_v[i] = 9; end
    Mem_Index_reset = 1; #1; Mem_Index_reset = 0;
    input_data_from_file = 16'h0909; output_data_from_file = 16'd55;
    load_from_file = 1; repeat (5) step();
    Mem_reset = 1; #1;
    n_vec++;
    if (test_w !== 12'h0) begin n_err++; $display("FAIL memreset_waddr: got %h want 000", test_w); end
    Mem_reset = 0; load_from_file = 0;
    step();
    do_run(1);
    n_vec++;
    if (result !== 16'd0) begin n_err++; $display("FAIL memreset_clear: got %0d want 0", result); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_square_writeback();
    test_wrap_max();
    test_preload();
    test_random();
    test_pause();
    test_comp_reset_mid();
    test_load_wrap();
    test_mem_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
